canny_gradient_pipeline: RTL and testbench
==========================================

# canny_gradient_pipeline

Streaming front end of the Canny edge detector: accepts raster-order 8-bit grayscale pixels, applies a 3x3 Gaussian blur, then a 3x3 Sobel operator, and emits per-pixel gradient magnitude, quantized direction and 8-bit debug images. Internally it chains `pixel_loader` (3x3 window builder), `gaussian_filter`, a second `pixel_loader`, and `gradient_calculation`. It feeds non-maximum suppression.

## Interface
- `IMG_WIDTH`, 512: pixels per image row; sizes both line buffers.
- `clk` input 1: single clock; everything is sampled on its rising edge.
- `rstN` input 1: reset; synchronous and active-high.
- `pixel_in` input 8: unsigned input pixel.
- `pixel_in_valid` input 1: `pixel_in` is accepted this cycle. There is no backpressure.
- `gaussian_pixel_out` output 8: blurred pixel.
- `gaussian_pixel_out_valid` output 1: qualifies `gaussian_pixel_out`.
- `pixel_out_x` output 8: min(|Gx|, 255).
- `pixel_out_y` output 8: min(|Gy|, 255).
- `pixel_xy_valid` output 1: qualifies `pixel_out_x` and `pixel_out_y`.
- `gradient_magnitude` output 11: |Gx| + |Gy|, range 0..2040.
- `gradient_direction` output 2: quantized gradient direction.
- `pixel_out` output 8: min(`gradient_magnitude`, 255).
- `gradient_out_valid` output 1: qualifies `gradient_magnitude`, `gradient_direction` and `pixel_out`.

## Operation
- **Window builder (`pixel_loader`)**
  - Two IMG_WIDTH-deep line buffers plus a 3x3 shift register.
  - Each accepted pixel advances the buffers and the window by one.
  - A counter of accepted pixels saturates once it reaches 2*IMG_WIDTH+2.
  - The window is valid for each accepted pixel whose index k (0-based) is ≥ 2*IMG_WIDTH+2.
  - The window is 72 bits. Element w[r][c] (r=0 oldest row/top, c=0 oldest column/left) sits at bits [71-8*(3r+c) -: 8], so the newest pixel is at [7:0].
  - There is no border handling. Windows that straddle a row wrap are emitted like any other.
- **Gaussian filter**
  - S = w00 + 2w01 + w02 + 2w10 + 4w11 + 2w12 + w20 + 2w21 + w22, computed at 12 bits.
  - Output is S>>4 (truncating), which never exceeds 255.
- **Gradient stage 1**
  - Gx = (w02 + 2w12 + w22) − (w00 + 2w10 + w20).
  - Gy = (w20 + 2w21 + w22) − (w00 + 2w01 + w02).
  - Both are 11-bit signed, range ±1020.
  - Registers |Gx|, |Gy|, the signs, and the saturated `pixel_out_x`/`pixel_out_y`.
- **Gradient stage 2**
  - Magnitude = |Gx| + |Gy|; `pixel_out` is the magnitude saturated to 255.
  - Direction, with ax=|Gx| and ay=|Gy|:
    - 0 if ax = ay = 0, or if 5·ay < 2·ax (0°).
    - else 2 if 2·ay > 5·ax (90°).
    - else 1 if sign(Gx) = sign(Gy), where zero counts as positive (45°).
    - else 3 (135°).
- **Output counts:** for N input pixels, the Gaussian stage produces N−(2W+2) outputs and the gradient stage produces N−(4W+4), with W = IMG_WIDTH. For a 512x512 image that is 261118 and 260092.
- **Reset:**
  - Clears all counters, pipeline registers and outputs; all outputs read 0 after reset.
  - Line-buffer contents need not be cleared.
  - A reset mid-stream discards all in-flight data, and the window fill restarts from pixel index 0.

## Timing
- Every stage is registered and fully pipelined, accepting one pixel per cycle.
- Take pixel index k accepted at edge t:
  - Window 1 valid at t+1.
  - `gaussian_pixel_out_valid` at t+2, for k ≥ 2W+2.
  - Window 2 valid at t+3.
  - `pixel_xy_valid` at t+4, for k ≥ 4W+4.
  - `gradient_out_valid` at t+5.
- Each valid is a single-cycle pulse per result.
- Gaps in `pixel_in_valid` propagate as gaps: no state advances on a cycle without valid data, and the output sequence is identical to the gap-free stream.
- Data outputs hold their last value while their valid is low.
- If reset and valid input occur in the same cycle, reset wins and the pixel is dropped.

## Test plan
Use IMG_WIDTH=8 unless stated.
1. **Reset:** hold `rstN`=1 for 2 cycles with `pixel_in_valid`=1 → all outputs are 0 and no valid ever pulses.
2. **Constant image:** 64 pixels of value 100 → 46 Gaussian outputs, all 100; 28 gradient outputs with magnitude 0, direction 0, `pixel_out`=0, x=y=0.
3. **Latency:** stream an incrementing pattern → the first `gaussian_pixel_out_valid` comes 2 cycles after accepting pixel 18; the first `pixel_xy_valid` 4 cycles after pixel 36; the first `gradient_out_valid` 5 cycles after pixel 36.
4. **Horizontal stripes:** rows 0–3 = 0 and rows 4–7 = 160.
   - Gaussian rows take the values 0, 40, 120, 160.
   - A gradient window over Gaussian rows 0/40/120, with all three columns in one row, gives Gy=480, Gx=0. Expect magnitude 480, `pixel_out`=255, `pixel_out_y`=255, `pixel_out_x`=0, direction 2.
5. **Gaps:** repeat test 2 with `pixel_in_valid` low for 5 cycles after pixel 30 → output counts and values are unchanged, and no valid pulses during the gap.
6. **Mid-stream reset:** reset after pixel 40, then stream 64 pixels of 100 → counts are again 46 and 28, with no stale outputs.

Source files
------------

// File: rtl/canny_gradient_pipeline.sv
// Canny front end: 3x3 window -> Gaussian blur -> 3x3 window -> Sobel gradient.
// One pixel per cycle, no backpressure; gaps in the input valid propagate as gaps.

module pixel_loader #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    output logic [71:0] window,
    output logic        window_valid
);
    localparam int LIM = 2 * IMG_WIDTH + 2;
    localparam int CW  = $clog2(LIM + 1);
    localparam int PW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [7:0]    lb1_q [IMG_WIDTH];
    logic [7:0]    lb2_q [IMG_WIDTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [71:0]   win_q, win_d;
    logic          vld_q, vld_d;
    logic [7:0]    tap1, tap2;

    // tap1 is the pixel one row back, tap2 two rows back
    assign tap1 = lb1_q[ptr_q];
    assign tap2 = lb2_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        win_d = win_q;
        vld_d = 1'b0;
        if (in_valid) begin
            ptr_d = (ptr_q == PW'(IMG_WIDTH - 1)) ? '0 : ptr_q + 1'b1;
            cnt_d = (cnt_q == CW'(LIM)) ? cnt_q : cnt_q + 1'b1;
            win_d = {win_q[63:48], tap2, win_q[39:24], tap1, win_q[15:0], in_pixel};
            vld_d = (cnt_q == CW'(LIM));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            win_q <= '0;
            vld_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            win_q <= win_d;
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            lb1_q[ptr_q] <= in_pixel;
            lb2_q[ptr_q] <= tap1;
        end
    end

    assign window       = win_q;
    assign window_valid = vld_q;
endmodule

module gaussian_filter (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] window,
    input  logic        window_valid,
    output logic [7:0]  pix_out,
    output logic        pix_out_valid
);
    logic [7:0]  pix_q, pix_d;
    logic        vld_q, vld_d;
    logic [11:0] sum;

    function automatic logic [11:0] px(input logic [71:0] w, input int r, input int c);
        return {4'b0, w[71 - 8 * (3 * r + c) -: 8]};
    endfunction

    always_comb begin
        sum = px(window, 0, 0) + (px(window, 0, 1) << 1) + px(window, 0, 2)
            + (px(window, 1, 0) << 1) + (px(window, 1, 1) << 2) + (px(window, 1, 2) << 1)
            + px(window, 2, 0) + (px(window, 2, 1) << 1) + px(window, 2, 2);
        pix_d = window_valid ? 8'(sum >> 4) : pix_q;
        vld_d = window_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            vld_q <= 1'b0;
        end else begin
            pix_q <= pix_d;
            vld_q <= vld_d;
        end
    end

    assign pix_out       = pix_q;
    assign pix_out_valid = vld_q;
endmodule

module gradient_calculation (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] window,
    input  logic        window_valid,
    output logic [7:0]  pixel_out_x,
    output logic [7:0]  pixel_out_y,
    output logic        pixel_xy_valid,
    output logic [10:0] gradient_magnitude,
    output logic [1:0]  gradient_direction,
    output logic [7:0]  pixel_out,
    output logic        gradient_out_valid
);
    logic signed [10:0] gx, gy;
    logic [9:0]  pos_x, neg_x, pos_y, neg_y;
    logic [9:0]  ax_q, ax_d, ay_q, ay_d;
    logic        sx_q, sx_d, sy_q, sy_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        s1_vld_q, s1_vld_d;
    logic [10:0] mag_q, mag_d;
    logic [1:0]  dir_q, dir_d;
    logic [7:0]  pout_q, pout_d;
    logic        s2_vld_q, s2_vld_d;

    function automatic logic [9:0] px(input logic [71:0] w, input int r, input int c);
        return {2'b0, w[71 - 8 * (3 * r + c) -: 8]};
    endfunction

    function automatic logic [7:0] sat8(input logic [10:0] v);
        return (v > 11'd255) ? 8'hFF : v[7:0];
    endfunction

    // |v| fits 10 bits since the Sobel range is +/-1020
    function automatic logic [9:0] abs10(input logic signed [10:0] v);
        return v[10] ? (~v[9:0] + 10'd1) : v[9:0];
    endfunction

    // tan(22.5) ~ 2/5 and tan(67.5) ~ 5/2 bound the horizontal and vertical sectors
    function automatic logic [1:0] quant_dir(input logic [9:0] ax, input logic [9:0] ay,
                                             input logic sx, input logic sy);
        logic [12:0] ax2, ay2, ax5, ay5;
        ax2 = {2'b0, ax, 1'b0};
        ay2 = {2'b0, ay, 1'b0};
        ax5 = {3'b0, ax} * 13'd5;
        ay5 = {3'b0, ay} * 13'd5;
        if ((ax == 10'd0 && ay == 10'd0) || ay5 < ax2) return 2'd0;
        else if (ay2 > ax5)                           return 2'd2;
        else if (sx == sy)                            return 2'd1;
        else                                          return 2'd3;
    endfunction

    // stage 1: Sobel sums, magnitudes, signs
    always_comb begin
        pos_x = px(window, 0, 2) + (px(window, 1, 2) << 1) + px(window, 2, 2);
        neg_x = px(window, 0, 0) + (px(window, 1, 0) << 1) + px(window, 2, 0);
        pos_y = px(window, 2, 0) + (px(window, 2, 1) << 1) + px(window, 2, 2);
        neg_y = px(window, 0, 0) + (px(window, 0, 1) << 1) + px(window, 0, 2);
        gx = $signed({1'b0, pos_x}) - $signed({1'b0, neg_x});
        gy = $signed({1'b0, pos_y}) - $signed({1'b0, neg_y});
        ax_d = ax_q;
        ay_d = ay_q;
        sx_d = sx_q;
        sy_d = sy_q;
        x_d  = x_q;
        y_d  = y_q;
        s1_vld_d = window_valid;
        if (window_valid) begin
            ax_d = abs10(gx);
            ay_d = abs10(gy);
            sx_d = gx[10];
            sy_d = gy[10];
            x_d  = sat8({1'b0, abs10(gx)});
            y_d  = sat8({1'b0, abs10(gy)});
        end
    end

    // stage 2: magnitude and direction
    always_comb begin
        mag_d  = mag_q;
        dir_d  = dir_q;
        pout_d = pout_q;
        s2_vld_d = s1_vld_q;
        if (s1_vld_q) begin
            mag_d  = {1'b0, ax_q} + {1'b0, ay_q};
            dir_d  = quant_dir(ax_q, ay_q, sx_q, sy_q);
            pout_d = sat8({1'b0, ax_q} + {1'b0, ay_q});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ax_q     <= '0;
            ay_q     <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            s1_vld_q <= 1'b0;
            mag_q    <= '0;
            dir_q    <= '0;
            pout_q   <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            s1_vld_q <= s1_vld_d;
            mag_q    <= mag_d;
            dir_q    <= dir_d;
            pout_q   <= pout_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    assign pixel_out_x        = x_q;
    assign pixel_out_y        = y_q;
    assign pixel_xy_valid     = s1_vld_q;
    assign gradient_magnitude = mag_q;
    assign gradient_direction = dir_q;
    assign pixel_out          = pout_q;
    assign gradient_out_valid = s2_vld_q;
endmodule

module canny_gradient_pipeline #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic [7:0]  gaussian_pixel_out,
    output logic        gaussian_pixel_out_valid,
    output logic [7:0]  pixel_out_x,
    output logic [7:0]  pixel_out_y,
    output logic        pixel_xy_valid,
    output logic [10:0] gradient_magnitude,
    output logic [1:0]  gradient_direction,
    output logic [7:0]  pixel_out,
    output logic        gradient_out_valid
);
    logic [71:0] win1, win2;
    logic        win1_vld, win2_vld;

    pixel_loader #(.IMG_WIDTH(IMG_WIDTH)) u_load1 (
        .clk(clk), .rst(rstN), .in_valid(pixel_in_valid), .in_pixel(pixel_in),
        .window(win1), .window_valid(win1_vld)
    );

    gaussian_filter u_gauss (
        .clk(clk), .rst(rstN), .window(win1), .window_valid(win1_vld),
        .pix_out(gaussian_pixel_out), .pix_out_valid(gaussian_pixel_out_valid)
    );

    pixel_loader #(.IMG_WIDTH(IMG_WIDTH)) u_load2 (
        .clk(clk), .rst(rstN), .in_valid(gaussian_pixel_out_valid),
        .in_pixel(gaussian_pixel_out), .window(win2), .window_valid(win2_vld)
    );

    gradient_calculation u_grad (
        .clk(clk), .rst(rstN), .window(win2), .window_valid(win2_vld),
        .pixel_out_x(pixel_out_x), .pixel_out_y(pixel_out_y),
        .pixel_xy_valid(pixel_xy_valid), .gradient_magnitude(gradient_magnitude),
        .gradient_direction(gradient_direction), .pixel_out(pixel_out),
        .gradient_out_valid(gradient_out_valid)
    );
endmodule

// File: tb/tb_canny_gradient_pipeline.sv
// Directed bench for canny_gradient_pipeline with an 8-pixel-wide image.

module tb_canny_gradient_pipeline;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [7:0]  pixel_in = '0;
    logic        pixel_in_valid = 1'b0;
    logic [7:0]  gaussian_pixel_out;
    logic        gaussian_pixel_out_valid;
    logic [7:0]  pixel_out_x, pixel_out_y, pixel_out;
    logic        pixel_xy_valid, gradient_out_valid;
    logic [10:0] gradient_magnitude;
    logic [1:0]  gradient_direction;

    canny_gradient_pipeline #(.IMG_WIDTH(W)) dut (
        .clk(clk), .rstN(rstN), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .gaussian_pixel_out(gaussian_pixel_out),
        .gaussian_pixel_out_valid(gaussian_pixel_out_valid),
        .pixel_out_x(pixel_out_x), .pixel_out_y(pixel_out_y),
        .pixel_xy_valid(pixel_xy_valid), .gradient_magnitude(gradient_magnitude),
        .gradient_direction(gradient_direction), .pixel_out(pixel_out),
        .gradient_out_valid(gradient_out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // output capture
    int g_n = 0, xy_n = 0, gr_n = 0;
    int g_first = -1, xy_first = -1, gr_first = -1;
    logic [7:0]  g_v [64];
    logic [7:0]  x_v [64];
    logic [7:0]  y_v [64];
    logic [10:0] m_v [64];
    logic [1:0]  d_v [64];
    logic [7:0]  p_v [64];

    always @(negedge clk) begin
        if (gaussian_pixel_out_valid) begin
            if (g_n < 64) g_v[g_n] = gaussian_pixel_out;
            if (g_n == 0) g_first = cyc;
            g_n++;
        end
        if (pixel_xy_valid) begin
            if (xy_n < 64) begin
                x_v[xy_n] = pixel_out_x;
                y_v[xy_n] = pixel_out_y;
            end
            if (xy_n == 0) xy_first = cyc;
            xy_n++;
        end
        if (gradient_out_valid) begin
            if (gr_n < 64) begin
                m_v[gr_n] = gradient_magnitude;
                d_v[gr_n] = gradient_direction;
                p_v[gr_n] = pixel_out;
            end
            if (gr_n == 0) gr_first = cyc;
            gr_n++;
        end
    end

    task automatic clear_mon();
        g_n = 0; xy_n = 0; gr_n = 0;
        g_first = -1; xy_first = -1; gr_first = -1;
    endtask

    int acc_cyc;
    int a18, a36;

    task automatic push(input logic [7:0] p);
        pixel_in = p;
        pixel_in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        pixel_in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        pixel_in_valid = 1'b0;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        rstN = 1'b0;
        clear_mon();
    endtask

    // modes: 0 const 100, 1 index ramp, 2 horizontal stripes, 3..5 linear ramps
    task automatic stream(input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            int r, c, v;
            r = k / W;
            c = k % W;
            case (mode)
                0: v = 100;
                1: v = k;
                2: v = (r >= 4) ? 160 : 0;
                3: v = 16 * c;
                4: v = 16 * c + 8 * r;
                default: v = 16 * c + 56 - 8 * r;
            endcase
            push(8'(v));
            if (k == 18) a18 = acc_cyc;
            if (k == 36) a36 = acc_cyc;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_g"},    gaussian_pixel_out, 0);
        chk({tag, "_gv"},   gaussian_pixel_out_valid, 0);
        chk({tag, "_x"},    pixel_out_x, 0);
        chk({tag, "_y"},    pixel_out_y, 0);
        chk({tag, "_xyv"},  pixel_xy_valid, 0);
        chk({tag, "_mag"},  gradient_magnitude, 0);
        chk({tag, "_dir"},  gradient_direction, 0);
        chk({tag, "_pout"}, pixel_out, 0);
        chk({tag, "_grv"},  gradient_out_valid, 0);
    endtask

    task automatic check_const(input string tag);
        chk({tag, "_g_n"},  g_n, 46);
        chk({tag, "_xy_n"}, xy_n, 28);
        chk({tag, "_gr_n"}, gr_n, 28);
        for (int i = 0; i < 46; i++) chk({tag, "_gval"}, g_v[i], 100);
        for (int i = 0; i < 28; i++)
            chk({tag, "_grad"}, {m_v[i], d_v[i], p_v[i], x_v[i], y_v[i]}, 0);
        chk({tag, "_hold_g"}, gaussian_pixel_out, 100);
    endtask

    task automatic check_grad(input string tag, input int m, input int mag, input int dir,
                              input int x, input int y, input int p);
        chk({tag, "_mag"},  m_v[m], mag);
        chk({tag, "_dir"},  d_v[m], dir);
        chk({tag, "_x"},    x_v[m], x);
        chk({tag, "_y"},    y_v[m], y);
        chk({tag, "_pout"}, p_v[m], p);
    endtask

    initial begin
        // reset held with valid input: pixels dropped, outputs zero
        rstN = 1'b1;
        pixel_in = 8'd55;
        pixel_in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_outputs_zero("rst");
        rstN = 1'b0;
        idle(6);
        check_outputs_zero("post_rst");
        chk("rst_g_n", g_n, 0);
        chk("rst_gr_n", gr_n, 0);

        // constant image
        do_reset();
        stream(0, 64);
        idle(8);
        check_const("const");

        // latency with an index ramp; blur of a linear ramp is its centre pixel
        do_reset();
        stream(1, 64);
        idle(8);
        chk("lat_gauss", g_first + 1 - a18, 2);
        chk("lat_xy",    xy_first + 1 - a36, 4);
        chk("lat_grad",  gr_first + 1 - a36, 5);
        chk("ramp_g0",   g_v[0], 9);
        chk("ramp_g_n",  g_n, 46);
        check_grad("ramp", 0, 72, 2, 8, 64, 72);

        // horizontal stripes
        do_reset();
        stream(2, 64);
        idle(8);
        chk("stripe_g11", g_v[11], 0);
        chk("stripe_g19", g_v[19], 40);
        chk("stripe_g27", g_v[27], 120);
        chk("stripe_g35", g_v[35], 160);
        check_grad("stripe_m1", 1, 160, 2, 0, 160, 160);
        check_grad("stripe_m9", 9, 480, 2, 0, 255, 255);

        // direction sectors from linear ramps (window centred at row 3, col 3)
        do_reset();
        stream(3, 64);
        idle(8);
        chk("hramp_g", g_v[18], 48);
        check_grad("hramp", 9, 128, 0, 128, 0, 128);

        do_reset();
        stream(4, 64);
        idle(8);
        chk("diag45_g", g_v[18], 72);
        check_grad("diag45", 9, 192, 1, 128, 64, 192);

        do_reset();
        stream(5, 64);
        idle(8);
        chk("diag135_g", g_v[18], 80);
        check_grad("diag135", 9, 192, 3, 128, 64, 192);

        // gap after pixel 30
        do_reset();
        stream(0, 31);
        idle(5);
        chk("gap_g_n",  g_n, 13);
        chk("gap_xy_n", xy_n, 0);
        chk("gap_gr_n", gr_n, 0);
        for (int k = 31; k < 64; k++) push(8'd100);
        idle(8);
        check_const("gap");

        // reset mid-stream after pixel 40
        do_reset();
        stream(1, 41);
        pixel_in_valid = 1'b0;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        rstN = 1'b0;
        clear_mon();
        check_outputs_zero("mid_rst");
        stream(0, 64);
        idle(8);
        check_const("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d expected %0d", cyc, 0);
        $fatal(1);
    end
endmodule
